// File: rtl/vga_timing_pkg.sv
// Shared timing records, standard mode constants and colour-bar table
// for the VGA raster timing generator.
package vga_timing_pkg;

    typedef struct packed {
        logic [11:0] sync;
        logic [11:0] bp;
        logic [11:0] visible;
        logic [11:0] fp;
    } timing_t;

    // 640x480 @ 60 Hz, 25.175 MHz nominal pixel clock
    localparam timing_t H_640X480 = '{sync: 12'd96,  bp: 12'd48, visible: 12'd640, fp: 12'd16};
    localparam timing_t V_640X480 = '{sync: 12'd2,   bp: 12'd33, visible: 12'd480, fp: 12'd10};

    // 800x600 @ 72 Hz, 50 MHz pixel clock
    localparam timing_t H_800X600 = '{sync: 12'd120, bp: 12'd64, visible: 12'd800, fp: 12'd56};
    localparam timing_t V_800X600 = '{sync: 12'd6,   bp: 12'd23, visible: 12'd600, fp: 12'd37};

    // {r,g,b} full-scale flags per bar; entry 0 is the leftmost bar
    localparam logic [7:0][2:0] BAR_COLORS = {
        3'b000,  // black
        3'b001,  // blue
        3'b100,  // red
        3'b101,  // magenta
        3'b010,  // green
        3'b011,  // cyan
        3'b110,  // yellow
        3'b111   // white
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_COLORS[idx];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear, used to
// align timing flags with the renderer's pixel pipeline.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing core: counters, coordinate stage, latency-matched
// sync/blank/RGB output stage and an 8-bar colour test pattern.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC     = int'(H_640X480.sync),
    parameter int H_BP       = int'(H_640X480.bp),
    parameter int H_VISIBLE  = int'(H_640X480.visible),
    parameter int H_FP       = int'(H_640X480.fp),
    parameter int V_SYNC     = int'(V_640X480.sync),
    parameter int V_BP       = int'(V_640X480.bp),
    parameter int V_VISIBLE  = int'(V_640X480.visible),
    parameter int V_FP       = int'(V_640X480.fp),
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIX_LAT    = 1,
    parameter int CW         = 11,
    parameter int COLOR_W    = 4
) (
    input  logic               clk_vga,
    input  logic               rst_vga_n,
    input  logic               i_tp_en,
    input  logic [COLOR_W-1:0] i_r,
    input  logic [COLOR_W-1:0] i_g,
    input  logic [COLOR_W-1:0] i_b,
    output logic [CW-1:0]      o_x,
    output logic [CW-1:0]      o_y,
    output logic               o_active,
    output logic               o_frame_start,
    output logic               o_line_start,
    output logic               o_vga_hs,
    output logic               o_vga_vs,
    output logic               o_vga_de,
    output logic [COLOR_W-1:0] o_vga_r,
    output logic [COLOR_W-1:0] o_vga_g,
    output logic [COLOR_W-1:0] o_vga_b
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_VISIBLE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_VISIBLE + V_FP;
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam int DL_W    = CW + 3;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT0     = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_ACT1     = CW'(H_SYNC + H_BP + H_VISIBLE);
    localparam logic [CW-1:0] V_ACT0     = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_ACT1     = CW'(V_SYNC + V_BP + V_VISIBLE);
    localparam logic [CW-1:0] BAR_LAST   = CW'(BAR_W - 1);

    logic [CW-1:0] hcnt_p0, vcnt_p0;
    logic          vld_p0, hs_p0, vs_p0;
    logic [CW-1:0] x_p0, y_p0;

    logic [CW-1:0] x_p1, y_p1;
    logic          vld_p1, frame_start_p1, line_start_p1;

    logic [DL_W-1:0] dl_in, dl_out;
    logic            vld_p2, hs_p2, vs_p2;
    logic [CW-1:0]   x_p2;

    logic          tp_mode;
    logic [2:0]    bar_idx, bar_idx_cur;
    logic [CW-1:0] bar_cnt, bar_cnt_cur;
    logic [2:0]    bar_rgb_p2;

    // Stage p0: raster counters
    always_ff @(posedge clk_vga) begin
        if (!rst_vga_n) begin
            hcnt_p0 <= '0;
            vcnt_p0 <= '0;
        end else if (hcnt_p0 == H_LAST) begin
            hcnt_p0 <= '0;
            vcnt_p0 <= (vcnt_p0 == V_LAST) ? '0 : vcnt_p0 + CW'(1);
        end else begin
            hcnt_p0 <= hcnt_p0 + CW'(1);
        end
    end

    always_comb begin
        vld_p0 = (hcnt_p0 >= H_ACT0) && (hcnt_p0 < H_ACT1) &&
                 (vcnt_p0 >= V_ACT0) && (vcnt_p0 < V_ACT1);
        hs_p0  = hcnt_p0 < H_SYNC_END;
        vs_p0  = vcnt_p0 < V_SYNC_END;
        x_p0   = vld_p0 ? hcnt_p0 - H_ACT0 : '0;
        y_p0   = vld_p0 ? vcnt_p0 - V_ACT0 : '0;
    end

    // Mode is captured only at raster origin so a frame never changes source mid-way
    always_ff @(posedge clk_vga) begin
        if (!rst_vga_n) begin
            tp_mode <= 1'b0;
        end else if (hcnt_p0 == '0 && vcnt_p0 == '0) begin
            tp_mode <= i_tp_en;
        end
    end

    // Stage p1: coordinate outputs to the renderer
    always_ff @(posedge clk_vga) begin
        if (!rst_vga_n) begin
            x_p1           <= '0;
            y_p1           <= '0;
            vld_p1         <= 1'b0;
            frame_start_p1 <= 1'b0;
            line_start_p1  <= 1'b0;
        end else begin
            x_p1           <= x_p0;
            y_p1           <= y_p0;
            vld_p1         <= vld_p0;
            frame_start_p1 <= vld_p0 && (x_p0 == '0) && (y_p0 == '0);
            line_start_p1  <= vld_p0 && (x_p0 == '0);
        end
    end

    assign o_x           = x_p1;
    assign o_y           = y_p1;
    assign o_active      = vld_p1;
    assign o_frame_start = frame_start_p1;
    assign o_line_start  = line_start_p1;

    // Stage p2: flags delayed to line up with the renderer's i_r/g/b
    assign dl_in = {vld_p0, hs_p0, vs_p0, x_p0};

    vga_delay_line #(
        .DEPTH (PIX_LAT + 1),
        .WIDTH (DL_W)
    ) u_delay (
        .clk   (clk_vga),
        .rst_n (rst_vga_n),
        .d     (dl_in),
        .q     (dl_out)
    );

    assign {vld_p2, hs_p2, vs_p2, x_p2} = dl_out;

    // Bar position tracked by counting pixels, restarted at each line's x=0
    always_comb begin
        bar_idx_cur = (x_p2 == '0) ? 3'd0 : bar_idx;
        bar_cnt_cur = (x_p2 == '0) ? '0 : bar_cnt;
        bar_rgb_p2  = bar_rgb(bar_idx_cur);
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_vga_n) begin
            bar_idx <= 3'd0;
            bar_cnt <= '0;
        end else if (vld_p2) begin
            if (bar_cnt_cur == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx_cur + 3'd1;
            end else begin
                bar_cnt <= bar_cnt_cur + CW'(1);
                bar_idx <= bar_idx_cur;
            end
        end
    end

    // Stage p3: registered connector outputs
    always_ff @(posedge clk_vga) begin
        if (!rst_vga_n) begin
            o_vga_de <= 1'b0;
            o_vga_hs <= ~H_SYNC_POL;
            o_vga_vs <= ~V_SYNC_POL;
            o_vga_r  <= '0;
            o_vga_g  <= '0;
            o_vga_b  <= '0;
        end else begin
            o_vga_de <= vld_p2;
            o_vga_hs <= hs_p2 ? H_SYNC_POL : ~H_SYNC_POL;
            o_vga_vs <= vs_p2 ? V_SYNC_POL : ~V_SYNC_POL;
            if (!vld_p2) begin
                o_vga_r <= '0;
                o_vga_g <= '0;
                o_vga_b <= '0;
            end else if (tp_mode) begin
                o_vga_r <= {COLOR_W{bar_rgb_p2[2]}};
                o_vga_g <= {COLOR_W{bar_rgb_p2[1]}};
                o_vga_b <= {COLOR_W{bar_rgb_p2[0]}};
            end else begin
                o_vga_r <= i_r;
                o_vga_g <= i_g;
                o_vga_b <= i_b;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster: random renderer pixels and
// random test-pattern requests checked cycle by cycle against a position model.
module tb_vga_timing_gen;

    localparam int HS = 8, HB = 4, HV = 32, HF = 4;
    localparam int VS = 2, VB = 3, VV = 6,  VF = 2;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FT = HT * VT;
    localparam int PL = 3;
    localparam int BW = HV / 8;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tp_en;
    logic [3:0]  ir, ig, ib;
    logic [10:0] o_x, o_y;
    logic        o_active, o_frame_start, o_line_start;
    logic        o_vga_hs, o_vga_vs, o_vga_de;
    logic [3:0]  o_vga_r, o_vga_g, o_vga_b;

    int n_vec = 0;
    int n_err = 0;
    int e;
    bit agg;
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, ls_cnt;
    bit tp_frame [64];
    logic [11:0] pix_tbl [HV*VV];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_VISIBLE(HV), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_VISIBLE(VV), .V_FP(VF),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL),
        .PIX_LAT(PL), .CW(11), .COLOR_W(4)
    ) dut (
        .clk_vga       (clk),
        .rst_vga_n     (rst_n),
        .i_tp_en       (tp_en),
        .i_r           (ir),
        .i_g           (ig),
        .i_b           (ib),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_active      (o_active),
        .o_frame_start (o_frame_start),
        .o_line_start  (o_line_start),
        .o_vga_hs      (o_vga_hs),
        .o_vga_vs      (o_vga_vs),
        .o_vga_de      (o_vga_de),
        .o_vga_r       (o_vga_r),
        .o_vga_g       (o_vga_g),
        .o_vga_b       (o_vga_b)
    );

    // Where linear raster position p sits: p counts pixel clocks from origin
    function automatic void pos(input int p, output bit act, output int x, output int y,
                                output bit hsa, output bit vsa);
        int h = p % HT;
        int v = (p / HT) % VT;
        act = (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
        x   = act ? h - HS - HB : 0;
        y   = act ? v - VS - VB : 0;
        hsa = h < HS;
        vsa = v < VS;
    endfunction

    function automatic logic [11:0] bar_exp(input int bar);
        case (bar)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at e=%0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic chk_out_reset(input string tag);
        chk({tag, "_de"}, 32'(o_vga_de), 32'(0));
        chk({tag, "_hs"}, 32'(o_vga_hs), 32'(!HPOL));
        chk({tag, "_vs"}, 32'(o_vga_vs), 32'(!VPOL));
        chk({tag, "_rgb"}, 32'({o_vga_r, o_vga_g, o_vga_b}), 32'(0));
    endtask

    task automatic chk_all_reset();
        chk("rst_x", 32'(o_x), 32'(0));
        chk("rst_y", 32'(o_y), 32'(0));
        chk("rst_active", 32'(o_active), 32'(0));
        chk("rst_fs", 32'(o_frame_start), 32'(0));
        chk("rst_ls", 32'(o_line_start), 32'(0));
        chk_out_reset("rst");
    endtask

    // One clock edge: drive renderer/tp inputs, then check both output stages
    task automatic step();
        int  pin;
        bit  a, hsa, vsa;
        int  x, y;
        logic [11:0] exp_rgb;
        pin = e - PL - 2;
        if ($urandom_range(199) == 0) tp_en = ~tp_en;
        if ((e - 1) % FT == 0) tp_frame[((e - 1) / FT) % 64] = tp_en;
        {ir, ig, ib} = 12'($urandom);
        if (pin >= 0) begin
            pos(pin, a, x, y, hsa, vsa);
            if (a) {ir, ig, ib} = pix_tbl[x + y * HV];
        end
        @(posedge clk);
        #1;
        pos(e - 1, a, x, y, hsa, vsa);
        chk("o_active", 32'(o_active), 32'(a));
        chk("o_x", 32'(o_x), 32'(x));
        chk("o_y", 32'(o_y), 32'(y));
        chk("o_frame_start", 32'(o_frame_start), 32'(a && x == 0 && y == 0));
        chk("o_line_start", 32'(o_line_start), 32'(a && x == 0));
        if (agg && (e - 1) < FT) begin
            fs_cnt += int'(o_frame_start);
            ls_cnt += int'(o_line_start);
        end
        if (pin < 0) begin
            chk_out_reset("fill");
        end else begin
            pos(pin, a, x, y, hsa, vsa);
            if (!a) exp_rgb = 12'h000;
            else if (tp_frame[(pin / FT) % 64]) exp_rgb = bar_exp(x / BW);
            else exp_rgb = pix_tbl[x + y * HV];
            chk("o_vga_de", 32'(o_vga_de), 32'(a));
            chk("o_vga_hs", 32'(o_vga_hs), 32'(hsa ? HPOL : !HPOL));
            chk("o_vga_vs", 32'(o_vga_vs), 32'(vsa ? VPOL : !VPOL));
            chk("o_vga_rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'(exp_rgb));
            if (agg && pin < FT) begin
                de_cnt += int'(o_vga_de);
                hs_cnt += int'(o_vga_hs == HPOL);
                vs_cnt += int'(o_vga_vs == VPOL);
            end
        end
        e++;
    endtask

    initial begin
        for (int i = 0; i < HV * VV; i++) pix_tbl[i] = 12'($urandom);
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; ls_cnt = 0;
        agg   = 1'b0;
        e     = 0;
        rst_n = 1'b0;
        tp_en = 1'b1;
        {ir, ig, ib} = 12'hAAA;
        repeat (3) @(posedge clk);
        #1;
        chk_all_reset();

        rst_n = 1'b1;
        e     = 1;
        agg   = 1'b1;
        repeat (FT + PL + 4) step();
        agg = 1'b0;
        chk("de_per_frame", 32'(de_cnt), 32'(HV * VV));
        chk("hs_per_frame", 32'(hs_cnt), 32'(HS * VT));
        chk("vs_per_frame", 32'(vs_cnt), 32'(VS * HT));
        chk("fs_per_frame", 32'(fs_cnt), 32'(1));
        chk("ls_per_frame", 32'(ls_cnt), 32'(VV));

        repeat (FT + 7 * HT + 20) step();

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_all_reset();
        rst_n = 1'b1;
        e     = 1;
        tp_en = 1'b0;
        repeat (3 * FT) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
